// File: rtl/tnn_sched_pkg.sv
// rtl/tnn_sched_pkg.sv - shared types and constants for the TNN neuron scheduler
package tnn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int FAN_IN = 6;

  localparam logic [2:0] SLOT_A = 3'd0;
  localparam logic [2:0] SLOT_B = 3'd1;
  localparam logic [2:0] SLOT_C = 3'd2;
  localparam logic [2:0] SLOT_D = 3'd3;
  localparam logic [2:0] SLOT_E = 3'd4;
  localparam logic [2:0] SLOT_F = 3'd5;

  // Slot s of the packed operand bus lives at [s*in_bits +: in_bits].
  function automatic int slot_lsb(input int slot, input int in_bits);
    return slot * in_bits;
  endfunction

endpackage

// File: rtl/tnn_operand_table.sv
// rtl/tnn_operand_table.sv - per-neuron operand index register file
module tnn_operand_table #(
  parameter int N_NEURONS  = 8,
  parameter int N_FEATURES = 11,
  parameter int FAN_IN     = tnn_sched_pkg::FAN_IN,
  parameter int IDX_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(N_NEURONS)-1:0]  wr_neuron,
  input  logic [2:0]                    wr_slot,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [$clog2(N_NEURONS)-1:0]  rd_neuron,
  output logic [FAN_IN*IDX_W-1:0]       rd_row,
  output logic [FAN_IN-1:0]             rd_in_range
);
  localparam int CNT_W = $clog2(N_NEURONS);

  logic [IDX_W-1:0] entry [N_NEURONS][FAN_IN];
  logic             wr_ok;

  assign wr_ok = we && (int'(wr_neuron) < N_NEURONS) && (int'(wr_slot) < FAN_IN);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        for (int s = 0; s < FAN_IN; s++) begin
          entry[n][s] <= '0;
        end
      end
    end else if (wr_ok) begin
      entry[wr_neuron][wr_slot] <= wr_idx;
    end
  end

  // Row select by comparison so a non-power-of-two neuron count never indexes past the array.
  always_comb begin
    rd_row      = '0;
    rd_in_range = '0;
    for (int n = 0; n < N_NEURONS; n++) begin
      if (rd_neuron == CNT_W'(n)) begin
        for (int s = 0; s < FAN_IN; s++) begin
          rd_row[s*IDX_W +: IDX_W] = entry[n][s];
        end
      end
    end
    for (int s = 0; s < FAN_IN; s++) begin
      rd_in_range[s] = int'(rd_row[s*IDX_W +: IDX_W]) < N_FEATURES;
    end
  end

endmodule

// File: rtl/tnn_neuron_scheduler.sv
// rtl/tnn_neuron_scheduler.sv - time-multiplexes one 6-operand TNN core across a layer
module tnn_neuron_scheduler #(
  parameter int N_NEURONS  = 8,
  parameter int N_FEATURES = 11,
  parameter int IN_BITS    = 3,
  parameter int FAN_IN     = 6,
  parameter int IDX_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0]   cfg_neuron,
  input  logic [2:0]                     cfg_slot,
  input  logic [IDX_W-1:0]               cfg_idx,
  input  logic                           feat_valid,
  output logic                           feat_ready,
  input  logic [N_FEATURES*IN_BITS-1:0]  feat_data,
  output logic [FAN_IN*IN_BITS-1:0]      core_operands,
  input  logic                           core_out,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [N_NEURONS-1:0]           res_data,
  output logic                           busy
);
  import tnn_sched_pkg::*;

  localparam int              CNT_W = $clog2(N_NEURONS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_NEURONS - 1);

  state_t                         state, state_next;
  logic [CNT_W-1:0]               cnt;
  logic [N_FEATURES*IN_BITS-1:0]  feat_lat, feat_sel;
  logic [CNT_W-1:0]               rd_neuron;
  logic [FAN_IN*IDX_W-1:0]        rd_row;
  logic [FAN_IN-1:0]              rd_in_range;
  logic [FAN_IN*IN_BITS-1:0]      ops_next;
  logic                           last;
  logic                           tbl_we;

  assign last   = (cnt == LAST);
  assign tbl_we = cfg_we && (state == ST_IDLE);

  tnn_operand_table #(
    .N_NEURONS  (N_NEURONS),
    .N_FEATURES (N_FEATURES),
    .FAN_IN     (FAN_IN),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .we          (tbl_we),
    .wr_neuron   (cfg_neuron),
    .wr_slot     (cfg_slot),
    .wr_idx      (cfg_idx),
    .rd_neuron   (rd_neuron),
    .rd_row      (rd_row),
    .rd_in_range (rd_in_range)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    feat_ready = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        feat_ready = 1'b1;
        if (feat_valid) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_next = ST_OUT;
      end
      ST_OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // In IDLE the accept edge must see the incoming vector and neuron 0's row directly.
  always_comb begin
    feat_sel  = (state == ST_IDLE) ? feat_data : feat_lat;
    rd_neuron = (state == ST_IDLE) ? '0 : cnt + CNT_W'(1);
    ops_next  = '0;
    for (int s = 0; s < FAN_IN; s++) begin
      for (int k = 0; k < N_FEATURES; k++) begin
        if (rd_in_range[s] && (rd_row[s*IDX_W +: IDX_W] == IDX_W'(k))) begin
          ops_next[slot_lsb(s, IN_BITS) +: IN_BITS] = feat_sel[k*IN_BITS +: IN_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      feat_lat      <= '0;
      core_operands <= '0;
      res_data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (feat_valid) begin
            feat_lat      <= feat_data;
            core_operands <= ops_next;
            cnt           <= '0;
          end
        end
        ST_RUN: begin
          res_data[cnt] <= core_out;
          if (!last) begin
            cnt           <= cnt + CNT_W'(1);
            core_operands <= ops_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
